// File: rtl/exe_pkg.sv
// ============================================================================
// exe_pkg : EXE_cmd encodings, multiplier FSM states, iteration counts
// Revision: 1.0
// ============================================================================
`default_nettype none

package exe_pkg;

  localparam logic [3:0] EXE_ADD = 4'b0000;
  localparam logic [3:0] EXE_SUB = 4'b0010;
  localparam logic [3:0] EXE_AND = 4'b0100;
  localparam logic [3:0] EXE_OR  = 4'b0101;
  localparam logic [3:0] EXE_NOR = 4'b0110;
  localparam logic [3:0] EXE_XOR = 4'b0111;
  localparam logic [3:0] EXE_SLL = 4'b1000;
  localparam logic [3:0] EXE_SRA = 4'b1001;
  localparam logic [3:0] EXE_SRL = 4'b1010;
  localparam logic [3:0] EXE_MUL = 4'b1100;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

  localparam int MUL_ITERS_R2 = 32;
  localparam int MUL_ITERS_R4 = 16;

endpackage

`default_nettype wire

// File: rtl/exe_mul_seq.sv
// ============================================================================
// exe_mul_seq : iterative low-32 multiplier (radix-2 shift-add or radix-4 Booth)
// Revision: 1.0
// ============================================================================
`default_nettype none

module exe_mul_seq
  import exe_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter bit USE_R4 = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] product
);

  localparam logic [4:0] LAST = USE_R4 ? 5'(MUL_ITERS_R4 - 1) : 5'(MUL_ITERS_R2 - 1);

  mul_state_e      state_q, state_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic            prev_q, prev_d;
  logic [4:0]      cnt_q, cnt_d;

  logic [XLEN-1:0] step_add;
  logic [XLEN-1:0] mcand_nxt;
  logic [XLEN-1:0] mplier_nxt;
  logic            prev_nxt;

  generate
    if (USE_R4) begin : g_radix4
      // Booth digit from {b[i+1], b[i], b[i-1]}; only the low XLEN bits matter.
      always_comb begin
        step_add = '0;
        case ({mplier_q[1:0], prev_q})
          3'b001, 3'b010: step_add = mcand_q;
          3'b011:         step_add = mcand_q << 1;
          3'b100:         step_add = -(mcand_q << 1);
          3'b101, 3'b110: step_add = -mcand_q;
          default:        step_add = '0;
        endcase
      end
      assign mcand_nxt  = mcand_q << 2;
      assign mplier_nxt = mplier_q >> 2;
      assign prev_nxt   = mplier_q[1];
    end else begin : g_radix2
      assign step_add   = mplier_q[0] ? mcand_q : '0;
      assign mcand_nxt  = mcand_q << 1;
      assign mplier_nxt = mplier_q >> 1;
      assign prev_nxt   = prev_q;
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prev_d   = prev_q;
    cnt_d    = cnt_q;
    case (state_q)
      MUL_IDLE: begin
        if (start) begin
          state_d  = MUL_RUN;
          acc_d    = '0;
          mcand_d  = a;
          mplier_d = b;
          prev_d   = 1'b0;
          cnt_d    = '0;
        end
      end
      MUL_RUN: begin
        acc_d    = acc_q + step_add;
        mcand_d  = mcand_nxt;
        mplier_d = mplier_nxt;
        prev_d   = prev_nxt;
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == LAST) state_d = MUL_DONE;
      end
      MUL_DONE: state_d = MUL_IDLE;
      default:  state_d = MUL_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= MUL_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prev_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
    end
  end

  // Reset overrides the combinational accept so stall is low while reset is held.
  assign busy    = ~rst & (((state_q == MUL_IDLE) & start) | (state_q == MUL_RUN));
  assign done    = (state_q == MUL_DONE);
  assign product = acc_q;

endmodule

`default_nettype wire

// File: rtl/exe_stage.sv
// ============================================================================
// exe_stage : MIPS execute stage - ALU, branch adder, iterative MUL with stall.
// Define EXE_FAST_MUL_EN for the radix-4 multiplier (17-cycle stall).
// Revision: 1.0
// ============================================================================
`default_nettype none

module exe_stage
  import exe_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int MUL_RADIX_LOG2 = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] PC_in,
  input  logic [XLEN-1:0] Val1_in,
  input  logic [XLEN-1:0] Val2_in,
  input  logic [XLEN-1:0] Reg2_in,
  input  logic [4:0]      dest_in,
  input  logic [3:0]      EXE_cmd_in,
  input  logic            Br_taken_in,
  input  logic            MEM_R_en_in,
  input  logic            MEM_W_en_in,
  input  logic            WB_en_in,
  output logic [XLEN-1:0] ALU_result,
  output logic [XLEN-1:0] Br_Addr,
  output logic            Br_taken,
  output logic [XLEN-1:0] Reg2,
  output logic [4:0]      dest,
  output logic            MEM_R_en,
  output logic            MEM_W_en,
  output logic            WB_en,
  output logic            stall
);

`ifdef EXE_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
`else
  localparam bit FAST_MUL = 1'b0;
`endif
  localparam bit USE_R4 = FAST_MUL || (MUL_RADIX_LOG2 == 2);

  logic            mul_start;
  logic            mul_busy;
  logic            mul_done;
  logic [XLEN-1:0] mul_product;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] result;

  assign mul_start = (EXE_cmd_in == EXE_MUL);

  exe_mul_seq #(
    .XLEN   (XLEN),
    .USE_R4 (USE_R4)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (Val1_in),
    .b       (Val2_in),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    alu_res = '0;
    case (EXE_cmd_in)
      EXE_ADD: alu_res = Val1_in + Val2_in;
      EXE_SUB: alu_res = Val1_in - Val2_in;
      EXE_AND: alu_res = Val1_in & Val2_in;
      EXE_OR:  alu_res = Val1_in | Val2_in;
      EXE_NOR: alu_res = ~(Val1_in | Val2_in);
      EXE_XOR: alu_res = Val1_in ^ Val2_in;
      EXE_SLL: alu_res = Val1_in << Val2_in[4:0];
      EXE_SRA: alu_res = $signed(Val1_in) >>> Val2_in[4:0];
      EXE_SRL: alu_res = Val1_in >> Val2_in[4:0];
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    result = alu_res;
    if (mul_busy)                  result = '0;
    else if (mul_done & mul_start) result = mul_product;
  end

  assign ALU_result = result;
  assign Br_Addr    = PC_in + (Val2_in << 2);
  assign Br_taken   = Br_taken_in & ~mul_busy;
  assign MEM_R_en   = MEM_R_en_in & ~mul_busy;
  assign MEM_W_en   = MEM_W_en_in & ~mul_busy;
  assign WB_en      = WB_en_in & ~mul_busy;
  assign Reg2       = Reg2_in;
  assign dest       = dest_in;
  assign stall      = mul_busy;

endmodule

`default_nettype wire

// File: tb/tb_exe_stage.sv
// ============================================================================
// tb_exe_stage : randomized self-checking bench for exe_stage
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_exe_stage;

`ifdef EXE_FAST_MUL_EN
  localparam int EXP_STALL = 17;
`else
  localparam int EXP_STALL = 33;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PC_in, Val1_in, Val2_in, Reg2_in;
  logic [4:0]  dest_in;
  logic [3:0]  EXE_cmd_in;
  logic        Br_taken_in, MEM_R_en_in, MEM_W_en_in, WB_en_in;
  logic [31:0] ALU_result, Br_Addr, Reg2;
  logic        Br_taken;
  logic [4:0]  dest;
  logic        MEM_R_en, MEM_W_en, WB_en, stall;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exe_stage dut (
    .clk(clk), .rst(rst),
    .PC_in(PC_in), .Val1_in(Val1_in), .Val2_in(Val2_in), .Reg2_in(Reg2_in),
    .dest_in(dest_in), .EXE_cmd_in(EXE_cmd_in), .Br_taken_in(Br_taken_in),
    .MEM_R_en_in(MEM_R_en_in), .MEM_W_en_in(MEM_W_en_in), .WB_en_in(WB_en_in),
    .ALU_result(ALU_result), .Br_Addr(Br_Addr), .Br_taken(Br_taken),
    .Reg2(Reg2), .dest(dest), .MEM_R_en(MEM_R_en), .MEM_W_en(MEM_W_en),
    .WB_en(WB_en), .stall(stall)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: instruction semantics computed with plain 64-bit arithmetic.
  function automatic logic [31:0] ref_alu(input logic [3:0] cmd, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] wide;
    case (cmd)
      4'b0000: return a + b;
      4'b0010: return a - b;
      4'b0100: return a & b;
      4'b0101: return a | b;
      4'b0110: return ~(a | b);
      4'b0111: return a ^ b;
      4'b1000: return a << b[4:0];
      4'b1001: begin wide = {{32{a[31]}}, a} >> b[4:0]; return wide[31:0]; end
      4'b1010: return a >> b[4:0];
      4'b1100: begin wide = {32'd0, a} * {32'd0, b}; return wide[31:0]; end
      default: return 32'd0;
    endcase
  endfunction

  task automatic drive(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic br, input logic mr,
                       input logic mw, input logic wb);
    EXE_cmd_in  = cmd;
    Val1_in     = a;
    Val2_in     = b;
    PC_in       = pc;
    Br_taken_in = br;
    MEM_R_en_in = mr;
    MEM_W_en_in = mw;
    WB_en_in    = wb;
    Reg2_in     = $urandom;
    dest_in     = 5'($urandom);
  endtask

  // Single-cycle op: outputs must be valid in the same cycle, no stall.
  task automatic do_op(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic br, input logic mr,
                       input logic mw, input logic wb);
    drive(cmd, a, b, pc, br, mr, mw, wb);
    @(negedge clk);
    check("alu_result", ALU_result, ref_alu(cmd, a, b));
    check("br_addr", Br_Addr, pc + b * 32'd4);
    check("br_taken", {31'd0, Br_taken}, {31'd0, br});
    check("mem_r_en", {31'd0, MEM_R_en}, {31'd0, mr});
    check("mem_w_en", {31'd0, MEM_W_en}, {31'd0, mw});
    check("wb_en", {31'd0, WB_en}, {31'd0, wb});
    check("reg2", Reg2, Reg2_in);
    check("dest", {27'd0, dest}, {27'd0, dest_in});
    check("stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic run_mul(input logic [31:0] a, input logic [31:0] b);
    int  stalls = 0;
    bit  bubble_ok = 1'b1;
    drive(4'b1100, a, b, 32'h0000_1000, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!stall) break;
      stalls++;
      if (WB_en || MEM_R_en || MEM_W_en || Br_taken || ALU_result != 32'd0) bubble_ok = 1'b0;
    end
    check("mul_stall_len", stalls, EXP_STALL);
    check("mul_bubble", {31'd0, bubble_ok}, 32'd1);
    check("mul_result", ALU_result, ref_alu(4'b1100, a, b));
    check("mul_done_wb", {31'd0, WB_en}, 32'd1);
    check("mul_done_br", {31'd0, Br_taken}, 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [3:0] cmd;
    rst = 1'b1;
    drive(4'b1100, 32'd5, 32'd9, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("reset_stall_mul", {31'd0, stall}, 32'd0);
    check("reset_wb_pass", {31'd0, WB_en}, 32'd1);
    drive(4'b0000, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    do_op(4'b0000, 32'h7FFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    do_op(4'b1001, 32'hF000_0000, 32'd4, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    do_op(4'b1010, 32'hF000_0000, 32'd4, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    do_op(4'b0000, 32'd0, 32'hFFFF_FFFE, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0);
    check("branch_target_abs", Br_Addr, 32'h0000_00F8);

    for (int n = 0; n < 40; n++) begin
      cmd = 4'($urandom);
      if (cmd == 4'b1100) cmd = 4'b0011;
      do_op(cmd, $urandom, $urandom, $urandom, 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom));
    end

    run_mul(32'hFFFF_FFFF, 32'd3);
    run_mul(32'd6, 32'd7);
    run_mul(32'h0001_0000, 32'h0001_0000);
    for (int n = 0; n < 5; n++) run_mul($urandom, $urandom);

    // Asynchronous reset in the middle of a multiply.
    drive(4'b1100, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    check("pre_reset_stall", {31'd0, stall}, 32'd1);
    #2 rst = 1'b1;
    #1 check("async_reset_stall", {31'd0, stall}, 32'd0);
    drive(4'b0000, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    do_op(4'b0000, 32'd100, 32'd23, 32'h40, 1'b0, 1'b0, 1'b0, 1'b1);
    run_mul(32'd11, 32'd13);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
